snake_prey_ctrl: RTL and testbench

SNAKE_PREY_CTRL -- requirements
Module: snake_prey_ctrl

---
 rtl/snake_prey_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_snake_prey_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_prey_ctrl.sv
// Prey spawner for the snake game: pulls candidates from a random generator,
// range-checks them, asks the snake body for occupancy and commits a free cell.
// Optional retry statistics counter is enabled by defining SNAKE_PREY_CTRL_STATS_EN.
module snake_prey_ctrl #(
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX   = 31,
    parameter int V_LOGIC_MAX   = 23,
    parameter int MAX_TRIES     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spawn_req,
    output logic                     gen_load,
    input  logic [H_LOGIC_WIDTH-1:0] cand_x,
    input  logic [V_LOGIC_WIDTH-1:0] cand_y,
    output logic                     qry_vld,
    output logic [H_LOGIC_WIDTH-1:0] qry_x,
    output logic [V_LOGIC_WIDTH-1:0] qry_y,
    input  logic                     qry_ack,
    input  logic                     qry_hit,
    output logic [H_LOGIC_WIDTH-1:0] prey_x,
    output logic [V_LOGIC_WIDTH-1:0] prey_y,
    output logic                     prey_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [15:0]              retry_cnt
);

    localparam logic [H_LOGIC_WIDTH-1:0] H_MAX_C = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] V_MAX_C = V_LOGIC_WIDTH'(V_LOGIC_MAX);
    localparam logic [7:0]               TRIES_C = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_BOUND  = 3'd2,
        ST_QUERY  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic [7:0]                 try_q, try_d;
    logic [7:0]                 try_inc_s;
    logic                       rej_s;
    logic [H_LOGIC_WIDTH-1:0]   qry_x_q, qry_x_d, prey_x_q, prey_x_d;
    logic [V_LOGIC_WIDTH-1:0]   qry_y_q, qry_y_d, prey_y_q, prey_y_d;
    logic                       prey_vld_q, prey_vld_d;
    logic                       gen_load_q, qry_vld_q, busy_q, done_q, fail_q;

    assign try_inc_s = try_q + 8'd1;

    // Next-state, pending-request and datapath selection.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        try_d      = try_q;
        qry_x_d    = qry_x_q;
        qry_y_d    = qry_y_q;
        prey_x_d   = prey_x_q;
        prey_y_d   = prey_y_q;
        prey_vld_d = prey_vld_q;
        rej_s      = 1'b0;

        // A single request can be queued behind a running spawn; extras are dropped.
        if (spawn_req && (state_q != ST_IDLE) && !pend_q) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (spawn_req || pend_q) begin
                    state_d    = ST_LOAD;
                    pend_d     = 1'b0;
                    try_d      = 8'd0;
                    prey_vld_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_BOUND;
            end
            ST_BOUND: begin
                qry_x_d = cand_x;
                qry_y_d = cand_y;
                if ((cand_x <= H_MAX_C) && (cand_y <= V_MAX_C)) begin
                    state_d = ST_QUERY;
                end else begin
                    rej_s = 1'b1;
                end
            end
            ST_QUERY: begin
                if (qry_ack && qry_hit) begin
                    rej_s = 1'b1;
                end else if (qry_ack) begin
                    state_d    = ST_COMMIT;
                    prey_x_d   = qry_x_q;
                    prey_y_d   = qry_y_q;
                    prey_vld_d = 1'b1;
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rej_s) begin
            try_d   = try_inc_s;
            state_d = (try_inc_s == TRIES_C) ? ST_FAIL : ST_LOAD;
        end else begin
            try_d = try_d;
        end
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            try_q      <= 8'd0;
            qry_x_q    <= '0;
            qry_y_q    <= '0;
            prey_x_q   <= '0;
            prey_y_q   <= '0;
            prey_vld_q <= 1'b0;
            gen_load_q <= 1'b0;
            qry_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            try_q      <= try_d;
            qry_x_q    <= qry_x_d;
            qry_y_q    <= qry_y_d;
            prey_x_q   <= prey_x_d;
            prey_y_q   <= prey_y_d;
            prey_vld_q <= prey_vld_d;
            gen_load_q <= (state_d == ST_LOAD);
            qry_vld_q  <= (state_d == ST_QUERY);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_COMMIT);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

`ifdef SNAKE_PREY_CTRL_STATS_EN
    logic [15:0] retry_q;

    // Saturating count of every rejected candidate; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 16'd0;
        end else if (rej_s && (retry_q != 16'hFFFF)) begin
            retry_q <= retry_q + 16'd1;
        end else begin
            retry_q <= retry_q;
        end
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 16'd0;
`endif

    assign gen_load = gen_load_q;
    assign qry_vld  = qry_vld_q;
    assign qry_x    = qry_x_q;
    assign qry_y    = qry_y_q;
    assign prey_x   = prey_x_q;
    assign prey_y   = prey_y_q;
    assign prey_vld = prey_vld_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_snake_prey_ctrl.sv
// Directed self-checking bench for snake_prey_ctrl (MAX_TRIES overridden to 4).
module tb_snake_prey_ctrl;

`ifdef SNAKE_PREY_CTRL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spawn_req = 1'b0;
    logic        gen_load;
    logic [4:0]  cand_x = 5'd0;
    logic [4:0]  cand_y = 5'd0;
    logic        qry_vld;
    logic [4:0]  qry_x, qry_y;
    logic        qry_ack = 1'b0;
    logic        qry_hit = 1'b0;
    logic [4:0]  prey_x, prey_y;
    logic        prey_vld, busy, done, fail;
    logic [15:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Generator / responder configuration written by the stimulus process only.
    logic [4:0] c0_x = 5'd0, c0_y = 5'd0, c1_x = 5'd0, c1_y = 5'd0;
    int         gen_base = 0;
    int         ack_delay = 0;
    logic       hit_mode = 1'b0;

    // Counters written by the monitor processes only.
    int gen_cnt = 0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int wait_cnt = 0;

    snake_prey_ctrl #(.MAX_TRIES(4)) dut (
        .clk(clk), .rst(rst), .spawn_req(spawn_req), .gen_load(gen_load),
        .cand_x(cand_x), .cand_y(cand_y), .qry_vld(qry_vld), .qry_x(qry_x),
        .qry_y(qry_y), .qry_ack(qry_ack), .qry_hit(qry_hit), .prey_x(prey_x),
        .prey_y(prey_y), .prey_vld(prey_vld), .busy(busy), .done(done),
        .fail(fail), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Candidate generator: first candidate of a spawn from c0, later ones from c1.
    always @(negedge clk) begin
        if (gen_load) begin
            if (gen_cnt == gen_base) begin
                cand_x = c0_x;
                cand_y = c0_y;
            end else begin
                cand_x = c1_x;
                cand_y = c1_y;
            end
            gen_cnt = gen_cnt + 1;
        end
    end

    // Occupancy responder: acks after ack_delay cycles of qry_vld.
    always @(negedge clk) begin
        if (qry_vld) begin
            if (wait_cnt == ack_delay) begin
                qry_ack  = 1'b1;
                qry_hit  = hit_mode;
                wait_cnt = 0;
            end else begin
                qry_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            qry_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Pulse counters.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (fail) fail_cnt = fail_cnt + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic spawn();
        @(negedge clk);
        spawn_req = 1'b1;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
    endtask

    // Posedges from the spawn-sampling edge until done or fail is seen.
    task automatic wait_end(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end while (!(done || fail) && lat < 200);
    endtask

    int lat;
    int g0, d0, f0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_prey_vld", prey_vld, 0);
        check_val("rst_gen_load", gen_load, 0);
        check_val("rst_qry_vld", qry_vld, 0);
        check_val("rst_done_fail", {done, fail}, 0);
        check_val("rst_prey_xy", {prey_x, prey_y}, 0);
        check_val("rst_retry", retry_cnt, 0);
        rst = 1'b0;

        // Basic spawn, ack one cycle after qry_vld
        c0_x = 5'd5; c0_y = 5'd7; ack_delay = 1; hit_mode = 1'b0; gen_base = gen_cnt;
        g0 = gen_cnt;
        spawn();
        wait_end(lat);
        check_val("basic_lat", lat, 4);
        check_val("basic_done", done, 1);
        check_val("basic_prey_x", prey_x, 5);
        check_val("basic_prey_y", prey_y, 7);
        check_val("basic_prey_vld", prey_vld, 1);
        @(posedge clk);
        #1;
        check_val("basic_done_pulse", done, 0);
        check_val("basic_busy_end", busy, 0);
        check_val("basic_gen", gen_cnt - g0, 1);
        check_val("basic_retry", retry_cnt, 0);

        // Out-of-range y, then a free in-range candidate
        c0_x = 5'd9; c0_y = 5'd28; c1_x = 5'd3; c1_y = 5'd3; ack_delay = 0;
        gen_base = gen_cnt; g0 = gen_cnt;
        spawn();
        wait_end(lat);
        check_val("bound_lat", lat, 5);
        check_val("bound_prey", {prey_x, prey_y}, {5'd3, 5'd3});
        check_val("bound_gen", gen_cnt - g0, 2);
        check_val("bound_retry", retry_cnt, STATS);

        // Every query hits: exhaust the four tries
        repeat (2) @(posedge clk);
        c0_x = 5'd1; c0_y = 5'd2; c1_x = 5'd1; c1_y = 5'd2; hit_mode = 1'b1;
        gen_base = gen_cnt; g0 = gen_cnt; d0 = done_cnt;
        spawn();
        wait_end(lat);
        check_val("fail_lat", lat, 12);
        check_val("fail_pulse", fail, 1);
        check_val("fail_no_done", done, 0);
        check_val("fail_prey", {prey_x, prey_y}, {5'd3, 5'd3});
        check_val("fail_prey_vld", prey_vld, 0);
        check_val("fail_gen", gen_cnt - g0, 4);
        @(posedge clk);
        #1;
        check_val("fail_one_cycle", fail, 0);
        check_val("fail_done_cnt", done_cnt - d0, 0);
        check_val("fail_retry", retry_cnt, 5 * STATS);

        // Two requests while busy -> exactly one extra spawn
        c0_x = 5'd10; c0_y = 5'd11; c1_x = 5'd10; c1_y = 5'd11;
        hit_mode = 1'b0; ack_delay = 3;
        gen_base = gen_cnt; g0 = gen_cnt; d0 = done_cnt;
        spawn();
        @(negedge clk); spawn_req = 1'b1;
        @(negedge clk); spawn_req = 1'b0;
        @(negedge clk); spawn_req = 1'b1;
        @(negedge clk); spawn_req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_val("pend_done_cnt", done_cnt - d0, 2);
        check_val("pend_gen", gen_cnt - g0, 2);
        check_val("pend_busy_end", busy, 0);
        check_val("pend_prey", {prey_x, prey_y}, {5'd10, 5'd11});

        // Reset during QUERY with a request pending
        ack_delay = 100; gen_base = gen_cnt; d0 = done_cnt; f0 = fail_cnt;
        spawn();
        lat = 0;
        while (!qry_vld && lat < 20) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        check_val("abort_reach_query", qry_vld, 1);
        @(negedge clk); spawn_req = 1'b1;
        @(negedge clk); spawn_req = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_qry_vld", qry_vld, 0);
        check_val("abort_prey_vld", prey_vld, 0);
        check_val("abort_prey_x", prey_x, 0);
        check_val("abort_done", done, 0);
        repeat (8) @(posedge clk);
        #1;
        check_val("abort_no_pend", busy, 0);
        check_val("abort_done_cnt", done_cnt - d0, 0);
        check_val("abort_fail_cnt", fail_cnt - f0, 0);
        check_val("abort_retry", retry_cnt, 0);

        // Slow ack: query address must hold steady
        c0_x = 5'd17; c0_y = 5'd20; ack_delay = 10; gen_base = gen_cnt;
        spawn();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat = lat + 1;
            if (qry_vld) begin
                check_val("slow_qry_xy", {qry_x, qry_y}, {5'd17, 5'd20});
            end
        end while (!done && lat < 200);
        check_val("slow_lat", lat, 13);
        check_val("slow_prey", {prey_x, prey_y, prey_vld}, {5'd17, 5'd20, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
